// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deserialises 11-bit frames
// and groups scan-code bytes into complete key events on a toggle-flagged 65-bit bus.
module ps2_key_rx #(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 11000
) (
    input  logic        clk,
    input  logic        delay_reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        rx_error
);

    localparam int unsigned FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic [1:0]    line_sync, filt_q;
    logic [FW-1:0] fcnt_q [2];
    logic          clk_prev_q;
    logic          fall, data_bit;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] idle_cnt_q;
    logic          timeout, stop_ok, stop_bad;
    logic          byte_valid_q;

    logic [63:0]   acc_q, acc_sh;
    logic [2:0]    e1_cnt_q;
    logic          is_fake;

    // Index 0 is the clock line, index 1 the data line.
    assign line_sync = {data_sync_q[1], clk_sync_q[1]};
    assign fall      = clk_prev_q & ~filt_q[0];
    assign data_bit  = filt_q[1];

    // A line level is accepted only after it has differed from the filtered value for FILTER cycles.
    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 2'b11;
            clk_prev_q  <= 1'b1;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            clk_prev_q  <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (line_sync[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FW'(FILTER - 1)) begin
                    filt_q[i] <= line_sync[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign timeout = (state_q != StIdle) && !fall && (idle_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) state_q <= StIdle;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else if (fall) begin
            case (state_q)
                StIdle:   if (!data_bit) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (fall && state_q == StStop) begin
            if (data_bit && (^{shift_q, par_q})) stop_ok  = 1'b1;
            else                                 stop_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            idle_cnt_q   <= '0;
            byte_valid_q <= 1'b0;
            rx_error     <= 1'b0;
        end else begin
            idle_cnt_q   <= (state_q == StIdle || fall) ? '0 : idle_cnt_q + 1'b1;
            byte_valid_q <= stop_ok;
            rx_error     <= stop_bad | timeout;
            if (fall) begin
                case (state_q)
                    StIdle: bit_cnt_q <= '0;
                    StData: begin
                        shift_q   <= {data_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    StParity: par_q <= data_bit;
                    default: ;
                endcase
            end
        end
    end

    // shift_q still holds the received byte in the cycle after the stop bit.
    assign acc_sh  = {acc_q[55:0], shift_q};
    assign is_fake = (acc_sh == 64'hE012) || (acc_sh == 64'hE0F012) ||
                     (acc_sh == 64'hE059) || (acc_sh == 64'hE0F059);

    always_ff @(posedge clk or posedge delay_reset) begin
        if (delay_reset) begin
            acc_q    <= '0;
            e1_cnt_q <= '0;
            ps2_key  <= '0;
        end else if (rx_error) begin
            acc_q    <= '0;
            e1_cnt_q <= '0;
        end else if (byte_valid_q) begin
            if (e1_cnt_q != 3'd0) begin
                e1_cnt_q <= e1_cnt_q - 1'b1;
                if (e1_cnt_q == 3'd1) begin
                    ps2_key <= {~ps2_key[64], acc_sh};
                    acc_q   <= '0;
                end else begin
                    acc_q <= acc_sh;
                end
            end else if (shift_q == 8'hE1) begin
                e1_cnt_q <= 3'd7;
                acc_q    <= acc_sh;
            end else if (shift_q == 8'hE0 || shift_q == 8'hF0) begin
                acc_q <= acc_sh;
            end else if (is_fake) begin
                acc_q <= '0;
            end else begin
                ps2_key <= {~ps2_key[64], acc_sh};
                acc_q   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: table of test-plan frames, randomized frames against a queue-based event
// model, and hand-written timeout / reset / glitch sequences.
module tb_ps2_key_rx;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 400;
    localparam int          H       = 25;

    logic        clk = 1'b0;
    logic        delay_reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [64:0] ps2_key;
    logic        rx_error;

    always #5 clk = ~clk;

    ps2_key_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .delay_reset (delay_reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ps2_key     (ps2_key),
        .rx_error    (rx_error)
    );

    int   nvec = 0;
    int   nmis = 0;
    int   tog_cnt = 0;
    int   err_cnt = 0;
    logic prev_bit = 1'b0;

    always @(negedge clk) begin
        if (!delay_reset && ps2_key[64] !== prev_bit) tog_cnt <= tog_cnt + 1;
        prev_bit <= ps2_key[64];
        if (rx_error === 1'b1) err_cnt <= err_cnt + 1;
    end

    // Reference model: bytes of the event in progress, newest at the back.
    logic [7:0]  mq[$];
    int          pause_len = 0;
    logic [63:0] exp_key = '0;
    logic        exp_bit = 1'b0;
    int          exp_tog = 0;
    int          exp_err = 0;

    function automatic logic [63:0] pack_q();
        logic [63:0] v = '0;
        foreach (mq[i]) v = {v[55:0], mq[i]};
        return v;
    endfunction

    task automatic model_emit();
        exp_key = pack_q();
        exp_bit = ~exp_bit;
        exp_tog++;
        mq.delete();
        pause_len = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [63:0] v;
        mq.push_back(b);
        if (mq.size() > 8) void'(mq.pop_front());
        if (pause_len > 0) begin
            pause_len++;
            if (pause_len == 8) model_emit();
        end else if (b == 8'hE1) begin
            pause_len = 1;
        end else if (!(b inside {8'hE0, 8'hF0})) begin
            v = pack_q();
            if (v inside {64'hE012, 64'hE0F012, 64'hE059, 64'hE0F059}) mq.delete();
            else model_emit();
        end
    endtask

    task automatic model_err();
        exp_err++;
        mq.delete();
        pause_len = 0;
    endtask

    task automatic check(input string name, input logic [64:0] got, input logic [64:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_state(input string name);
        check({name, " key"}, ps2_key, {exp_bit, exp_key});
        check({name, " toggles"}, 65'(tog_cnt), 65'(exp_tog));
        check({name, " errors"}, 65'(err_cnt), 65'(exp_err));
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par,
                                               input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (H) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(posedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        repeat (2 * H) @(posedge clk);
    endtask

    typedef struct {
        logic [7:0]  b;
        bit          bad_par;
        bit          bad_stop;
        logic [63:0] exp_key;
        int          exp_tog;
        int          exp_err;
    } vec_t;

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 64'h1C, 1, 0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 64'h1C, 1, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 64'h1C, 1, 0};
        vecs[3]  = '{8'h75, 1'b0, 1'b0, 64'hE0F075, 2, 0};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[5]  = '{8'hE1, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[6]  = '{8'h14, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[7]  = '{8'h77, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[8]  = '{8'hE1, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[9]  = '{8'hF0, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[10] = '{8'h14, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[11] = '{8'hF0, 1'b0, 1'b0, 64'h75, 3, 0};
        vecs[12] = '{8'h77, 1'b0, 1'b0, 64'hE11477E1F014F077, 4, 0};
        vecs[13] = '{8'h1C, 1'b1, 1'b0, 64'hE11477E1F014F077, 4, 1};
        vecs[14] = '{8'h1C, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[15] = '{8'hE0, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[16] = '{8'h12, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[17] = '{8'hE0, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[18] = '{8'hF0, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[19] = '{8'h12, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[20] = '{8'hE0, 1'b0, 1'b0, 64'h1C, 5, 1};
        vecs[21] = '{8'h7C, 1'b0, 1'b0, 64'hE07C, 6, 1};
        vecs[22] = '{8'h1C, 1'b0, 1'b1, 64'hE07C, 6, 2};
        vecs[23] = '{8'h1C, 1'b0, 1'b0, 64'h1C, 7, 2};

        repeat (5) @(posedge clk);
        delay_reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset key", ps2_key, 65'd0);
        check("reset rx_error", {64'd0, rx_error}, 65'd0);

        for (int i = 0; i < 24; i++) begin
            send_frame(vecs[i].b, vecs[i].bad_par, vecs[i].bad_stop);
            if (vecs[i].bad_par || vecs[i].bad_stop) model_err();
            else model_byte(vecs[i].b);
            check($sformatf("vec%0d key", i), {1'b0, ps2_key[63:0]}, {1'b0, vecs[i].exp_key});
            check($sformatf("vec%0d toggles", i), 65'(tog_cnt), 65'(vecs[i].exp_tog));
            check($sformatf("vec%0d errors", i), 65'(err_cnt), 65'(vecs[i].exp_err));
        end

        for (int i = 0; i < 40; i++) begin
            int          r;
            int          e;
            logic [7:0]  b;
            r = $urandom_range(0, 9);
            e = $urandom_range(0, 11);
            case (r)
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'h12;
                3:       b = 8'h59;
                4:       b = 8'hE1;
                default: b = 8'($urandom);
            endcase
            send_frame(b, e == 0, e == 1);
            if (e == 0 || e == 1) model_err();
            else model_byte(b);
            check_state($sformatf("rand%0d", i));
        end

        // Timeout mid-frame must also discard the pending E0 prefix.
        send_frame(8'hE0, 1'b0, 1'b0);
        model_byte(8'hE0);
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 6);
        repeat (TIMEOUT + 100) @(posedge clk);
        model_err();
        check_state("timeout");
        send_frame(8'h7C, 1'b0, 1'b0);
        model_byte(8'h7C);
        check_state("after timeout");

        // Reset in the middle of a frame.
        send_frame(8'hE0, 1'b0, 1'b0);
        model_byte(8'hE0);
        send_bits(frame_bits(8'h1C, 1'b0, 1'b0), 6);
        delay_reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midframe reset key", ps2_key, 65'd0);
        check("midframe reset rx_error", {64'd0, rx_error}, 65'd0);
        delay_reset = 1'b0;
        mq.delete();
        pause_len = 0;
        exp_key = '0;
        exp_bit = 1'b0;
        repeat (5) @(posedge clk);
        send_frame(8'h1C, 1'b0, 1'b0);
        model_byte(8'h1C);
        check_state("after reset");

        // A 3-cycle low glitch on the clock with data low must not start a frame.
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk  = 1'b1;
        repeat (2) @(posedge clk);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 100) @(posedge clk);
        check_state("glitch");
        send_frame(8'h1C, 1'b0, 1'b0);
        model_byte(8'h1C);
        check_state("after glitch");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
